// File: rtl/prbs_checker_pkg.sv
// prbs_checker_pkg: shared FSM state, default parameters and counter widths for the PRBS checker
package prbs_checker_pkg;
  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
  localparam int DEF_WIDTH = 8;
  localparam logic [7:0] DEF_TAPS = 8'b10110001;
  localparam int DEF_LOCK_CNT = 16;
  localparam int DEF_WINDOW = 16;
  localparam int DEF_ERR_THRESH = 4;
  localparam int ERR_W = 16;
  localparam int BIT_W = 32;
endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial data input, control and status bundle of the PRBS checker
interface prbs_checker_if;
  import prbs_checker_pkg::*;
  logic enable;
  logic data_in;
  logic clear;
  logic locked;
  logic bit_error;
  logic [ERR_W-1:0] err_count;
  logic [BIT_W-1:0] bit_count;
  modport master(output enable, data_in, clear, input locked, bit_error, err_count, bit_count);
  modport slave(input enable, data_in, clear, output locked, bit_error, err_count, bit_count);
endinterface

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter: up-counter that sticks at all-ones; clear beats increment
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc && ~&count) count <= count + 1'b1;
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: XNOR-LFSR PRBS checker with hunt/lock FSM, windowed loss-of-lock and saturating stats
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int WINDOW = DEF_WINDOW,
  parameter int ERR_THRESH = DEF_ERR_THRESH
) (
  input logic clk,
  input logic reset,
  prbs_checker_if.slave bus
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [FW-1:0] fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_errs, win_errs_nxt;
  logic pred, filled, hit, lock_now, mis, lose, win_end;
  always_comb begin
    pred = ~^(shreg & TAPS);
    filled = fill_cnt == FW'(WIDTH);
    hit = bus.data_in == pred;
    lock_now = state == HUNT && bus.enable && filled && hit && match_cnt == MW'(LOCK_CNT - 1);
    mis = state == LOCK && bus.enable && !hit;
    win_errs_nxt = win_errs + EW'(mis);
    lose = mis && win_errs_nxt == EW'(ERR_THRESH);
    win_end = win_bits == WW'(WINDOW - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HUNT;
    else state <= state_nxt;
  always_comb state_nxt = lock_now ? LOCK : lose ? HUNT : state;
  always_comb bus.locked = state == LOCK;
  // once locked, the register runs on its own prediction so line errors cannot corrupt it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shreg <= '0;
      fill_cnt <= '0;
      match_cnt <= '0;
      win_bits <= '0;
      win_errs <= '0;
      bus.bit_error <= 1'b0;
    end else begin
      bus.bit_error <= mis;
      if (bus.enable) begin
        shreg <= {shreg[WIDTH-2:0], state == LOCK ? pred : bus.data_in};
        if (state == HUNT) begin
          fill_cnt <= filled ? fill_cnt : fill_cnt + 1'b1;
          match_cnt <= (lock_now || !filled || !hit) ? '0 : match_cnt + 1'b1;
          win_bits <= '0;
          win_errs <= '0;
        end else if (lose) begin
          fill_cnt <= '0;
          match_cnt <= '0;
          win_bits <= '0;
          win_errs <= '0;
        end else begin
          win_bits <= win_end ? '0 : win_bits + 1'b1;
          win_errs <= win_end ? '0 : win_errs_nxt;
        end
      end
    end
  prbs_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk(clk), .reset(reset), .inc(mis), .clr(bus.clear), .count(bus.err_count)
  );
  prbs_sat_counter #(.W(BIT_W)) u_bit_cnt (
    .clk(clk), .reset(reset), .inc(state == LOCK && bus.enable), .clr(bus.clear), .count(bus.bit_count)
  );
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed + randomized checks of prbs_checker against a behavioural lock/error model
module tb_prbs_checker;
  import prbs_checker_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  prbs_checker_if bus();
  prbs_checker dut(.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] gen;
  int m_hunt, m_wbits, m_werrs;
  bit m_locked, m_be;
  longint m_err, m_bits;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    gen = '0;
    m_hunt = 0; m_wbits = 0; m_werrs = 0;
    m_locked = 0; m_be = 0; m_err = 0; m_bits = 0;
  endtask
  // one cycle of stimulus; flips are only applied while the model is locked
  task automatic step(bit en, bit flip, bit clr);
    bit b, f;
    @(negedge clk);
    b = ($countones(gen & DEF_TAPS) % 2) == 0;
    f = flip && m_locked;
    bus.enable = en;
    bus.data_in = b ^ f;
    bus.clear = clr;
    @(posedge clk);
    #1;
    m_be = 0;
    if (en) begin
      gen = {gen[6:0], b};
      if (!m_locked) begin
        m_hunt++;
        if (m_hunt == DEF_WIDTH + DEF_LOCK_CNT) begin m_locked = 1; m_wbits = 0; m_werrs = 0; end
      end else begin
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (f) begin
          if (m_err < 65535) m_err++;
          m_werrs++;
          m_be = 1;
        end
        m_wbits++;
        if (m_werrs == DEF_ERR_THRESH) begin m_locked = 0; m_hunt = 0; m_wbits = 0; m_werrs = 0; end
        else if (m_wbits == DEF_WINDOW) begin m_wbits = 0; m_werrs = 0; end
      end
    end
    if (clr) begin m_err = 0; m_bits = 0; end
    chk("locked", bus.locked, m_locked);
    chk("bit_error", bus.bit_error, m_be);
    chk("err_count", bus.err_count, m_err);
    chk("bit_count", bus.bit_count, m_bits);
    bus.clear = 1'b0;
  endtask
  task automatic align();
    for (int k = 0; k < 40 && m_wbits != 0; k++) step(1, 0, 0);
  endtask
  task automatic wait_lock();
    for (int k = 0; k < 100 && !m_locked; k++) step(1, 0, 0);
    chk("wait_lock", bus.locked, 1);
  endtask
  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.data_in = 1'b0;
    bus.clear = 1'b0;
    model_reset();
    #12;
    chk("rst_locked", bus.locked, 0);
    chk("rst_bit_error", bus.bit_error, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_bit_count", bus.bit_count, 0);
    chk("rst_state", dut.state, HUNT);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 23; i++) step(1, 0, 0);
    chk("lock_not_at_23", bus.locked, 0);
    step(1, 0, 0);
    chk("lock_at_24", bus.locked, 1);
    chk("lock_err0", bus.err_count, 0);
    step(1, 1, 0);
    chk("single_err_pulse", bus.bit_error, 1);
    chk("single_err_cnt", bus.err_count, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("single_err_keep_lock", bus.locked, 1);
    chk("single_err_no_more", bus.err_count, 1);
    step(1, 0, 1);
    align();
    for (int i = 0; i < 32; i++) step(1, i inside {2, 7, 11, 17, 20, 30}, 0);
    chk("3plus3_locked", bus.locked, 1);
    chk("3plus3_err", bus.err_count, 6);
    step(1, 0, 1);
    align();
    for (int i = 0; i < 13; i++) step(1, i inside {1, 4, 8, 12}, 0);
    chk("4err_unlock", bus.locked, 0);
    chk("4err_cnt", bus.err_count, 4);
    for (int i = 0; i < 23; i++) step(1, 0, 0);
    chk("relock_not_23", bus.locked, 0);
    step(1, 0, 0);
    chk("relock_24", bus.locked, 1);
    align();
    @(negedge clk);
    bus.enable = 1'b0;
    force dut.u_err_cnt.count = 16'hFFFE;
    #1;
    release dut.u_err_cnt.count;
    m_err = 16'hFFFE;
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    chk("sat_err", bus.err_count, 16'hFFFF);
    chk("sat_locked", bus.locked, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    step(1, 1, 1);
    chk("clear_wins", bus.err_count, 0);
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 0, 0);
    chk("gaps_no_err", bus.err_count, 0);
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, 0);
    wait_lock();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_locked", bus.locked, 0);
    chk("async_rst_bit_error", bus.bit_error, 0);
    chk("async_rst_err", bus.err_count, 0);
    chk("async_rst_bits", bus.bit_count, 0);
    chk("async_rst_state", dut.state, HUNT);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) step(1, 0, 0);
    chk("post_rst_relock", bus.locked, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
